// File: rtl/wb_data_upsize_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_data_upsize_pkg
//  Description : Shared types and helpers for the 8-to-32 bit Wishbone
//                upsizer: FSM state enum, byte-lane select from the low
//                address bits, and byte extraction from a 32-bit word.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_data_upsize_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One-hot lane for a byte address. Big-endian puts byte 0 on the top lane.
    function automatic logic [3:0] lane_sel(input logic [1:0] adr_lo,
                                            input logic       big);
        return big ? (4'b1000 >> adr_lo) : (4'b0001 << adr_lo);
    endfunction

    // Pick the byte on the lane flagged by a one-hot select.
    function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                             input logic [3:0]  sel);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                b = b | word[8*i +: 8];
            end
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_data_upsize_rdbuf.sv
`default_nettype none
// ============================================================================
//  Module      : wb_data_upsize_rdbuf
//  Description : One-word read buffer for the upsizer. Holds the last word
//                read from the slave with its word-address tag and a valid
//                bit, answers hit lookups, and merges bytes written through
//                the bridge into the buffered word.
//  Ports       : clk/rst_n     clock, async active-low reset
//                clear         invalidate the buffer
//                load/load_word  capture a slave read word under line_tag
//                upd/upd_sel/upd_byte  write-through merge when line_tag hits
//                line_tag      word address of the current slave access
//                look_tag/look_sel  master lookup address and lane
//                hit/hit_byte  lookup result
//  Revision    : 1.0  initial release
// ============================================================================
module wb_data_upsize_rdbuf
    import wb_data_upsize_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [31:0]   load_word,
    input  logic          upd,
    input  logic [3:0]    upd_sel,
    input  logic [7:0]    upd_byte,
    input  logic [AW-3:0] line_tag,
    input  logic [AW-3:0] look_tag,
    input  logic [3:0]    look_sel,
    output logic          hit,
    output logic [7:0]    hit_byte
);

    logic          valid;
    logic [AW-3:0] tag;
    logic [31:0]   word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= line_tag;
            word  <= load_word;
        end else if (upd && valid && (tag == line_tag)) begin
            // Keep the buffer coherent with writes that pass through us.
            for (int i = 0; i < 4; i++) begin
                if (upd_sel[i]) begin
                    word[8*i +: 8] <= upd_byte;
                end
            end
        end
    end

    assign hit      = valid && (tag == look_tag);
    assign hit_byte = lane_byte(word, look_sel);

endmodule
`default_nettype wire

// File: rtl/wb_data_upsize.sv
`default_nettype none
// ============================================================================
//  Module      : wb_data_upsize
//  Description : Sequential bridge from an 8-bit Wishbone master to a 32-bit
//                Wishbone slave. Every master byte access becomes one
//                registered classic-cycle word access with a one-hot select.
//                Optional macro WB_DATA_UPSIZE_RDBUF_EN adds a one-word read
//                buffer that answers repeated reads of the same word within
//                one master bus cycle without touching the slave.
//  Ports       : wb_clk_i, wb_rst_n_i       clock, async active-low reset
//                wbm_*                      8-bit master side (cti/bte ignored)
//                wbs_*                      32-bit slave side, all registered
//  Revision    : 1.0  initial release
// ============================================================================
module wb_data_upsize
    import wb_data_upsize_pkg::*;
#(
    parameter int    AW     = 32,
    parameter int    MDW    = 8,
    parameter int    SDW    = 32,
    parameter string ENDIAN = "big"
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n_i,
    input  logic [AW-1:0]  wbm_adr_i,
    input  logic [MDW-1:0] wbm_dat_i,
    input  logic           wbm_we_i,
    input  logic           wbm_cyc_i,
    input  logic           wbm_stb_i,
    input  logic [2:0]     wbm_cti_i,
    input  logic [1:0]     wbm_bte_i,
    output logic [MDW-1:0] wbm_dat_o,
    output logic           wbm_ack_o,
    output logic           wbm_err_o,
    output logic           wbm_rty_o,
    output logic [AW-1:0]  wbs_adr_o,
    output logic [SDW-1:0] wbs_dat_o,
    output logic [3:0]     wbs_sel_o,
    output logic           wbs_we_o,
    output logic           wbs_cyc_o,
    output logic           wbs_stb_o,
    output logic [2:0]     wbs_cti_o,
    output logic [1:0]     wbs_bte_o,
    input  logic [SDW-1:0] wbs_dat_i,
    input  logic           wbs_ack_i,
    input  logic           wbs_err_i,
    input  logic           wbs_rty_i
);

    localparam logic BIG_ENDIAN = (ENDIAN == "big");

    state_t     state;
    logic       aborted;
    logic [3:0] look_sel;
    logic       slv_term;
    logic       buf_hit;
    logic [7:0] buf_byte;
    logic       unused_ign;

    assign look_sel   = lane_sel(wbm_adr_i[1:0], BIG_ENDIAN);
    assign slv_term   = wbs_ack_i || wbs_err_i || wbs_rty_i;
    assign wbs_cti_o  = 3'b000;
    assign wbs_bte_o  = 2'b00;
    assign unused_ign = ^{wbm_cti_i, wbm_bte_i};

`ifdef WB_DATA_UPSIZE_RDBUF_EN
    logic buf_hit_raw;
    logic buf_clear;
    logic pure_ack;

    // Buffer lifetime ends with the master bus cycle or any failed access.
    assign buf_clear = ((state == ST_IDLE) && !wbm_cyc_i) ||
                       ((state == ST_BUS) && (wbs_err_i || wbs_rty_i));
    assign pure_ack  = (state == ST_BUS) && wbs_ack_i && !wbs_err_i && !wbs_rty_i;

    wb_data_upsize_rdbuf #(
        .AW (AW)
    ) u_rdbuf (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .clear     (buf_clear),
        .load      (pure_ack && !wbs_we_o),
        .load_word (wbs_dat_i),
        .upd       (pure_ack && wbs_we_o),
        .upd_sel   (wbs_sel_o),
        .upd_byte  (wbs_dat_o[7:0]),
        .line_tag  (wbs_adr_o[AW-1:2]),
        .look_tag  (wbm_adr_i[AW-1:2]),
        .look_sel  (look_sel),
        .hit       (buf_hit_raw),
        .hit_byte  (buf_byte)
    );

    // Writes never allocate and must always reach the slave.
    assign buf_hit = buf_hit_raw && !wbm_we_i;
`else
    assign buf_hit  = 1'b0;
    assign buf_byte = '0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= ST_IDLE;
            aborted   <= 1'b0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_sel_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        if (buf_hit) begin
                            wbm_dat_o <= buf_byte;
                            wbm_ack_o <= 1'b1;
                            state     <= ST_RESP;
                        end else begin
                            wbs_adr_o <= {wbm_adr_i[AW-1:2], 2'b00};
                            wbs_dat_o <= {4{wbm_dat_i}};
                            wbs_sel_o <= look_sel;
                            wbs_we_o  <= wbm_we_i;
                            wbs_cyc_o <= 1'b1;
                            wbs_stb_o <= 1'b1;
                            aborted   <= 1'b0;
                            state     <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // Remember a master abort even if cyc comes back later.
                    if (!wbm_cyc_i) begin
                        aborted <= 1'b1;
                    end
                    if (slv_term) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        if (aborted || !wbm_cyc_i) begin
                            state <= ST_IDLE;
                        end else begin
                            wbm_err_o <= wbs_err_i;
                            wbm_rty_o <= !wbs_err_i && wbs_rty_i;
                            wbm_ack_o <= !wbs_err_i && !wbs_rty_i && wbs_ack_i;
                            if (!wbs_err_i && !wbs_rty_i && !wbs_we_o) begin
                                wbm_dat_o <= lane_byte(wbs_dat_i, wbs_sel_o);
                            end
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    wbm_ack_o <= 1'b0;
                    wbm_err_o <= 1'b0;
                    wbm_rty_o <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_data_upsize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_data_upsize
//  Description : Self-checking bench for wb_data_upsize. A big-endian and a
//                little-endian instance see identical master traffic, each
//                with its own word-wide slave. Expectations come from a
//                byte-addressed memory model and a simple buffer-hit model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_data_upsize;

    localparam int AW = 32;
`ifdef WB_DATA_UPSIZE_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // master side (shared)
    logic [31:0] m_adr;
    logic [7:0]  m_dat;
    logic        m_we, m_cyc, m_stb;
    logic [2:0]  m_cti = 3'b000;
    logic [1:0]  m_bte = 2'b00;
    logic [7:0]  m_rdat [2];
    logic [1:0]  m_ack, m_err, m_rty;

    // slave side, index 0 = big-endian, 1 = little-endian
    logic [31:0] s_adr [2];
    logic [31:0] s_dout [2];
    logic [31:0] s_din [2];
    logic [3:0]  s_sel [2];
    logic [2:0]  s_cti [2];
    logic [1:0]  s_bte [2];
    logic [1:0]  s_we, s_cyc, s_stb, s_ack, s_err, s_rty;

    // slave behaviour knobs: {err, rty, ack} and wait states
    logic [2:0]  sl_resp = 3'b001;
    int          sl_wait = 0;
    logic        mem_init = 1'b0;

    // reference model: byte-addressed memory seen by the master + buffer state
    logic [7:0]  ref_mem [512];
    bit          bv = 1'b0;
    logic [29:0] btag = '0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int bidx(input logic [31:0] a);
        return int'({a[13], a[7:0]});
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'({a[13], a[7:2]});
    endfunction

    wb_data_upsize #(.AW(AW), .MDW(8), .SDW(32), .ENDIAN("big")) u_big (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_rdat[0]), .wbm_ack_o(m_ack[0]), .wbm_err_o(m_err[0]), .wbm_rty_o(m_rty[0]),
        .wbs_adr_o(s_adr[0]), .wbs_dat_o(s_dout[0]), .wbs_sel_o(s_sel[0]), .wbs_we_o(s_we[0]),
        .wbs_cyc_o(s_cyc[0]), .wbs_stb_o(s_stb[0]), .wbs_cti_o(s_cti[0]), .wbs_bte_o(s_bte[0]),
        .wbs_dat_i(s_din[0]), .wbs_ack_i(s_ack[0]), .wbs_err_i(s_err[0]), .wbs_rty_i(s_rty[0])
    );

    wb_data_upsize #(.AW(AW), .MDW(8), .SDW(32), .ENDIAN("little")) u_lit (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(m_rdat[1]), .wbm_ack_o(m_ack[1]), .wbm_err_o(m_err[1]), .wbm_rty_o(m_rty[1]),
        .wbs_adr_o(s_adr[1]), .wbs_dat_o(s_dout[1]), .wbs_sel_o(s_sel[1]), .wbs_we_o(s_we[1]),
        .wbs_cyc_o(s_cyc[1]), .wbs_stb_o(s_stb[1]), .wbs_cti_o(s_cti[1]), .wbs_bte_o(s_bte[1]),
        .wbs_dat_i(s_din[1]), .wbs_ack_i(s_ack[1]), .wbs_err_i(s_err[1]), .wbs_rty_i(s_rty[1])
    );

    // Word-wide slaves: terminate combinationally after sl_wait stb cycles.
    for (genvar g = 0; g < 2; g++) begin : g_slv
        logic [31:0] mem [128];
        int          cnt = 0;
        int          wcnt = 0;
        logic        go;

        assign go       = s_cyc[g] && s_stb[g] && (wcnt == sl_wait);
        assign s_ack[g] = go && sl_resp[0];
        assign s_rty[g] = go && sl_resp[1];
        assign s_err[g] = go && sl_resp[2];
        assign s_din[g] = mem[widx(s_adr[g])];

        always @(posedge clk) begin
            if (mem_init) begin
                for (int k = 0; k < 128; k++) begin
                    if (g == 0) begin
                        mem[k] <= {ref_mem[4*k], ref_mem[4*k+1], ref_mem[4*k+2], ref_mem[4*k+3]};
                    end else begin
                        mem[k] <= {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
                    end
                end
            end else if (s_cyc[g] && s_stb[g]) begin
                if (go) begin
                    wcnt <= 0;
                    cnt  <= cnt + 1;
                    if (s_we[g] && (sl_resp == 3'b001)) begin
                        for (int j = 0; j < 4; j++) begin
                            if (s_sel[g][j]) begin
                                mem[widx(s_adr[g])][8*j +: 8] <= s_dout[g][8*j +: 8];
                            end
                        end
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                wcnt <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int slv_count(input int i);
        return (i == 0) ? g_slv[0].cnt : g_slv[1].cnt;
    endfunction

    // One master byte access. resp = {err, rty, ack}; keep = hold cyc after it.
    task automatic xfer(input logic [31:0] a, input bit we, input logic [7:0] d,
                        input logic [2:0] resp, input int wt, input bit keep);
        bit         hit;
        int         exp_n, got_n;
        int         c0 [2];
        logic [3:0] exp_sel [2];
        bit         e_err, e_rty, e_ack;

        hit        = RDBUF && !we && bv && (btag == a[31:2]);
        exp_sel[0] = 4'(1 << (3 - int'(a[1:0])));
        exp_sel[1] = 4'(1 << int'(a[1:0]));
        c0[0]      = slv_count(0);
        c0[1]      = slv_count(1);
        sl_resp    = resp;
        sl_wait    = wt;
        m_adr = a; m_we = we; m_dat = d; m_cyc = 1'b1; m_stb = 1'b1;
        exp_n = hit ? 1 : wt + 2;
        got_n = 0;
        for (int n = 1; n <= wt + 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                for (int i = 0; i < 2; i++) begin
                    if (hit) begin
                        chk("hit_no_stb", s_stb[i], 1'b0);
                    end else begin
                        chk("s_stb", {s_cyc[i], s_stb[i]}, 2'b11);
                        chk("s_adr", s_adr[i], {a[31:2], 2'b00});
                        chk("s_sel", s_sel[i], exp_sel[i]);
                        chk("s_we", s_we[i], we);
                        if (we) chk("s_dat", s_dout[i], {4{d}});
                    end
                end
            end
            if ((m_ack | m_err | m_rty) != 2'b00) begin
                got_n = n;
                break;
            end
        end
        chk("latency", got_n, exp_n);
        e_err = !hit && resp[2];
        e_rty = !hit && !resp[2] && resp[1];
        e_ack = !e_err && !e_rty;
        for (int i = 0; i < 2; i++) begin
            chk("term", {m_err[i], m_rty[i], m_ack[i]}, {e_err, e_rty, e_ack});
            if (!we && e_ack) chk("rdata", m_rdat[i], ref_mem[bidx(a)]);
        end
        m_stb = 1'b0;
        if (!keep) m_cyc = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("pulse", {m_err[i], m_rty[i], m_ack[i]}, 3'b000);
            chk("slv_acc", slv_count(i) - c0[i], hit ? 0 : 1);
        end
        if (!hit) begin
            if (resp[2] || resp[1]) begin
                bv = 1'b0;
            end else if (!we) begin
                bv   = 1'b1;
                btag = a[31:2];
            end else begin
                ref_mem[bidx(a)] = d;
            end
        end
        if (!keep) begin
            bv = 1'b0;
            @(negedge clk);
        end
    endtask

    // Master drops cyc while the slave access is outstanding.
    task automatic abort_rd(input logic [31:0] a);
        int   c0 [2];
        logic seen;
        c0[0] = slv_count(0);
        c0[1] = slv_count(1);
        sl_resp = 3'b001; sl_wait = 2;
        m_adr = a; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        @(negedge clk);
        chk("abort_stb", s_stb, 2'b11);
        m_cyc = 1'b0; m_stb = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            seen = seen | (|m_ack) | (|m_err) | (|m_rty);
        end
        chk("abort_noterm", seen, 1'b0);
        chk("abort_cyc", s_cyc, 2'b00);
        for (int i = 0; i < 2; i++) chk("abort_acc", slv_count(i) - c0[i], 1);
        bv = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ctl"}, {s_cyc[i], s_stb[i], s_we[i], m_ack[i], m_err[i], m_rty[i]}, 6'b0);
            chk({tag, "_dat"}, {s_adr[i], s_sel[i], m_rdat[i]}, 44'b0);
            chk({tag, "_wdat"}, s_dout[i], 32'b0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        logic [2:0]  resp;

        m_adr = '0; m_dat = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        for (int k = 0; k < 512; k++) ref_mem[k] = 8'($urandom);
        ref_mem[bidx(32'h1000)] = 8'hAA;
        ref_mem[bidx(32'h1001)] = 8'hBB;
        ref_mem[bidx(32'h1002)] = 8'hCC;
        ref_mem[bidx(32'h1003)] = 8'hDD;
        mem_init = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait read; big word reads back as AABBCCDD
        xfer(32'h0000_1001, 1'b0, 8'h00, 3'b001, 0, 1'b0);
        // byte write replicated on all lanes
        xfer(32'h0000_2003, 1'b1, 8'h5A, 3'b001, 0, 1'b0);
        // four reads of one word within one cycle
        for (int k = 0; k < 4; k++) xfer(32'h0000_1000 + k, 1'b0, 8'h00, 3'b001, 0, k < 3);
        // write-through into the buffered word, then cyc drop
        xfer(32'h0000_1000, 1'b0, 8'h00, 3'b001, 1, 1'b1);
        xfer(32'h0000_1002, 1'b1, 8'h11, 3'b001, 0, 1'b1);
        xfer(32'h0000_1002, 1'b0, 8'h00, 3'b001, 0, 1'b0);
        xfer(32'h0000_1000, 1'b0, 8'h00, 3'b001, 0, 1'b0);
        // err on read invalidates; next read of same word hits the slave
        xfer(32'h0000_1004, 1'b0, 8'h00, 3'b001, 0, 1'b1);
        xfer(32'h0000_1005, 1'b0, 8'h00, 3'b100, 1, 1'b1);
        xfer(32'h0000_1006, 1'b0, 8'h00, 3'b001, 0, 1'b0);
        // termination priority
        xfer(32'h0000_1008, 1'b0, 8'h00, 3'b111, 0, 1'b0);
        xfer(32'h0000_1009, 1'b0, 8'h00, 3'b011, 2, 1'b0);
        xfer(32'h0000_100A, 1'b1, 8'h77, 3'b011, 0, 1'b0);
        // master abort
        abort_rd(32'h0000_100C);
        xfer(32'h0000_100C, 1'b0, 8'h00, 3'b001, 0, 1'b0);

        // reset during BUS
        sl_resp = 3'b001; sl_wait = 6;
        m_adr = 32'h0000_2010; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_stb", s_stb, 2'b11);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bv = 1'b0;
        @(negedge clk);
        xfer(32'h0000_2010, 1'b0, 8'h00, 3'b001, 0, 1'b0);

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            a = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h0000_2000;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 255));
            else                           a = a | 32'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 7)       resp = 3'b001;
            else if (r == 7) resp = 3'b100;
            else if (r == 8) resp = 3'b010;
            else             resp = 3'($urandom_range(3, 7));
            if (it % 40 == 39) begin
                abort_rd(a);
            end else begin
                xfer(a, $urandom_range(0, 3) == 0, 8'($urandom), resp,
                     $urandom_range(0, 3), $urandom_range(0, 4) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_data_upsize.md
# wb_data_upsize

Sequential bridge between an 8-bit Wishbone master and a 32-bit Wishbone slave, the reverse direction of the byte-lane downsizer. Each master byte access becomes one registered, classic-cycle word access with a one-hot select. An optional one-word read buffer serves repeated byte reads within the same word without a slave access. It sits between narrow masters (UART-style DMA, debug bridges) and word-wide memory slaves in the interconnect.

## Interface
- `aw`, 32, address width
- `mdw`, 8, master data width (fixed 8)
- `sdw`, 32, slave data width (fixed 32)
- `endian`, "big", byte-lane order, "big" or "little"
- `wb_clk_i` in 1: single clock, all logic on its rising edge
- `wb_rst_n_i` in 1: reset, asynchronous assert, active-low
- `wbm_adr_i` in aw: byte address
- `wbm_dat_i` in 8: write data
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in 1: master controls
- `wbm_cti_i` in 3, `wbm_bte_i` in 2: accepted and ignored
- `wbm_dat_o` out 8: registered read data
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out 1: registered terminations
- `wbs_adr_o` out aw: `{wbm_adr_i[aw-1:2], 2'b00}`, registered
- `wbs_dat_o` out 32: master byte replicated on all four lanes
- `wbs_sel_o` out 4: one-hot lane select
- `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o` out 1: slave controls
- `wbs_cti_o` out 3: constant 3'b000; `wbs_bte_o` out 2: constant 2'b00
- `wbs_dat_i` in 32; `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1

## Operation
- Lane mapping, big: adr[1:0]=0→sel 4'b1000, dat[31:24]; 3→4'b0001, dat[7:0]. Little: adr[1:0]=0→4'b0001, dat[7:0]; 3→4'b1000, dat[31:24].
- FSM states IDLE, BUS, RESP:
  - IDLE with cyc&stb and a read-buffer hit: load the buffered byte into `wbm_dat_o` and go to RESP. There is no slave access.
  - IDLE with cyc&stb otherwise: latch adr, we, dat and sel into slave registers, assert `wbs_cyc_o`/`wbs_stb_o`, and go to BUS.
  - BUS on `wbs_ack_i|wbs_err_i|wbs_rty_i`: drop `wbs_cyc_o`/`wbs_stb_o` and register the matching master termination. On a read ack, also register the selected byte. Then go to RESP.
  - RESP: termination is high for exactly this cycle, then return to IDLE.
- Priority if a slave asserts several terminations together: err > rty > ack.
- Master abort (`wbm_cyc_i` low during BUS): the slave access runs to termination, no master termination is issued, and the FSM returns to IDLE.
- Writes never allocate in the buffer.
- All outputs reset to 0. Reset mid-access drops `wbs_cyc_o` immediately and the transaction is lost.

## Timing
- Miss: request sampled in cycle 0. `wbs_stb_o` is high from cycle 1. If the slave acks in cycle k (k≥1), `wbm_ack_o` is high in cycle k+1.
- Hit: `wbm_ack_o` high in cycle 1.
- Zero-wait slave: 2-cycle master latency.
- `wbm_stb_i` is not re-sampled in RESP. A new request is accepted no earlier than the cycle after RESP.

## Configuration
- `WB_DATA_UPSIZE_RDBUF_EN` defined: one-word buffer with valid bit and tag `adr[aw-1:2]`.
  - A read ack loads the whole `wbs_dat_i` word and sets valid.
  - A write ack to the tagged word updates that byte.
  - Valid is cleared by reset, by any err/rty, and by any IDLE cycle with `wbm_cyc_i` low. Buffer lifetime is therefore one master bus cycle.
- `WB_DATA_UPSIZE_RDBUF_EN` undefined: no buffer; every read is a miss. Ports and all other timing are unchanged.

## Structure
- Package `wb_data_upsize_pkg`: state enum (IDLE, BUS, RESP), lane-select function `(adr[1:0], endian) → sel[3:0]`, byte-extract function.
- Sub-module `wb_data_upsize_rdbuf`: word register, tag, valid, hit compare and byte-merge. Instantiated only under the macro.

## Test plan
- Big-endian read adr 0x1001, slave returns 0xAABBCCDD with zero wait → `wbs_sel_o`=4'b0100, `wbs_adr_o`=0x1000, `wbm_dat_o`=0xBB, ack in cycle 2.
- Little-endian write 0x5A to adr 0x2003 → `wbs_sel_o`=4'b1000, `wbs_dat_o`=0x5A5A5A5A, `wbs_we_o`=1, one ack.
- With macro, within one cyc, read 0x1000–0x1003 → one slave access, four acks, bytes AA, BB, CC, DD. Second to fourth acks arrive in cycle 1 after request.
- With macro, read 0x1000, write 0x11 to 0x1002, read 0x1002 in the same cyc → 0x11 returned from the buffer, no third slave access. Drop cyc for one cycle, read 0x1000 → slave access issued.
- Slave err on read → `wbm_err_o` pulse of one cycle. A following read of the same word goes to the slave.
- Assert `wb_rst_n_i` low during BUS → `wbs_cyc_o`/`wbs_stb_o` low in the same cycle, all outputs 0, FSM in IDLE after release.
